// File: rtl/dft_pkg.sv
// Shared definitions for the DFT datapath: butterfly op encodings and the
// saturation helper used by the add/sub stage and the bin accumulator.
package dft_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;  // a + b
    localparam logic [1:0] OP_SUB  = 2'b01;  // a - b
    localparam logic [1:0] OP_RSUB = 2'b10;  // b - a
    localparam logic [1:0] OP_SUBJ = 2'b11;  // a - j*b

    // Wide enough to hold any operand width this datapath is built for plus headroom.
    localparam int unsigned CALC_W = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    // Clamp an exact (mathematical) value into the range of a width-bit
    // signed or unsigned number. The caller detects clamping by comparing
    // the returned value with the input.
    function automatic calc_t sat_clip(input calc_t value, input int unsigned width,
                                       input bit is_signed);
        calc_t one;
        calc_t hi;
        calc_t lo;
        calc_t res;
        one = calc_t'(1);
        if (is_signed) begin
            hi = (one <<< (width - 1)) - one;
            lo = -(one <<< (width - 1));
        end else begin
            hi = (one <<< width) - one;
            lo = '0;
        end
        if (value > hi) begin
            res = hi;
        end else if (value < lo) begin
            res = lo;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/dft_pipe_stage.sv
// One valid/ready register slice. Loads whenever it is empty or its
// downstream neighbour takes the held beat; otherwise it holds everything.
module dft_pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/dft_cplx_addsub.sv
// Pipelined complex add/subtract butterfly with optional saturation, sticky
// overflow and sideband tag; arithmetic sits in front of the first slice.
module dft_cplx_addsub
    import dft_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter bit          DATA_SIGNED = 1'b1,
    parameter bit          SATURATE    = 1'b1,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 8,
    localparam int unsigned OUT_W      = SATURATE ? DATA_W : DATA_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [1:0]        s_op_i,
    input  logic [DATA_W-1:0] s_a_re_i,
    input  logic [DATA_W-1:0] s_a_im_i,
    input  logic [DATA_W-1:0] s_b_re_i,
    input  logic [DATA_W-1:0] s_b_im_i,
    input  logic [TAG_W-1:0]  s_tag_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [OUT_W-1:0]  m_re_o,
    output logic [OUT_W-1:0]  m_im_o,
    output logic [TAG_W-1:0]  m_tag_o,
    output logic              m_ovf_o,
    output logic              ovf_sticky_o,
    input  logic              clr_ovf_i
);

    localparam int unsigned PAY_W = 2 * OUT_W + 1 + TAG_W;

    function automatic calc_t ext(input logic [DATA_W-1:0] v);
        return calc_t'({{(CALC_W - DATA_W){DATA_SIGNED && v[DATA_W-1]}}, v});
    endfunction

    calc_t            a_re, a_im, b_re, b_im;
    calc_t            re_full, im_full;
    calc_t            clip_re, clip_im;
    logic [OUT_W-1:0] re_res, im_res;
    logic             ovf;
    logic [PAY_W-1:0] pay_in;

    always_comb begin
        a_re = ext(s_a_re_i);
        a_im = ext(s_a_im_i);
        b_re = ext(s_b_re_i);
        b_im = ext(s_b_im_i);
        case (s_op_i)
            OP_ADD: begin
                re_full = a_re + b_re;
                im_full = a_im + b_im;
            end
            OP_SUB: begin
                re_full = a_re - b_re;
                im_full = a_im - b_im;
            end
            OP_RSUB: begin
                re_full = b_re - a_re;
                im_full = b_im - a_im;
            end
            default: begin
                re_full = a_re + b_im;
                im_full = a_im - b_re;
            end
        endcase

        // The exact value is kept wide so unsigned underflow and overflow stay distinguishable.
        clip_re = sat_clip(re_full, DATA_W, DATA_SIGNED);
        clip_im = sat_clip(im_full, DATA_W, DATA_SIGNED);
        if (SATURATE) begin
            re_res = clip_re[OUT_W-1:0];
            im_res = clip_im[OUT_W-1:0];
            ovf    = (clip_re != re_full) || (clip_im != im_full);
        end else begin
            re_res = re_full[OUT_W-1:0];
            im_res = im_full[OUT_W-1:0];
            ovf    = 1'b0;
        end
        pay_in = {re_res, im_res, ovf, s_tag_i};
    end

    logic             unused_calc;
    assign unused_calc = ^{re_full[CALC_W-1:OUT_W], im_full[CALC_W-1:OUT_W],
                           clip_re[CALC_W-1:OUT_W], clip_im[CALC_W-1:OUT_W]};

    logic             stg_valid [PIPE_STAGES+1];
    logic             stg_ready [PIPE_STAGES+1];
    logic [PAY_W-1:0] stg_data  [PIPE_STAGES+1];

    assign stg_valid[0]           = s_valid_i;
    assign stg_data[0]            = pay_in;
    assign stg_ready[PIPE_STAGES] = m_ready_i;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        dft_pipe_stage #(
            .WIDTH(PAY_W)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .in_valid_i (stg_valid[k]),
            .in_ready_o (stg_ready[k]),
            .in_data_i  (stg_data[k]),
            .out_valid_o(stg_valid[k+1]),
            .out_ready_i(stg_ready[k+1]),
            .out_data_o (stg_data[k+1])
        );
    end

    assign s_ready_o = stg_ready[0];
    assign m_valid_o = stg_valid[PIPE_STAGES];
    assign {m_re_o, m_im_o, m_ovf_o, m_tag_o} = stg_data[PIPE_STAGES];

    logic ovf_sticky_q, ovf_sticky_d;

    // A clear wins over a same-cycle overflowing transfer.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (clr_ovf_i) begin
            ovf_sticky_d = 1'b0;
        end else if (m_valid_o && m_ready_i && m_ovf_o) begin
            ovf_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_sticky_o = ovf_sticky_q;

endmodule

// File: tb/tb_dft_cplx_addsub.sv
// Directed bench: signed/saturating main instance plus unsigned saturating and
// unsigned full-precision instances fed from the same stimulus.
module tb_dft_cplx_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid, m_ready, clr_ovf;
    logic [1:0]  s_op;
    logic [15:0] a_re, a_im, b_re, b_im;
    logic [7:0]  s_tag;

    logic        s_ready, m_valid, m_ovf, ovf_sticky;
    logic [15:0] m_re, m_im;
    logic [7:0]  m_tag;

    logic        unused_u_ready, u_m_valid, u_m_ovf, u_sticky;
    logic [15:0] u_re, u_im;
    logic [7:0]  unused_u_tag;

    logic        unused_n_ready, n_m_valid, n_m_ovf, n_sticky;
    logic [16:0] n_re, n_im;
    logic [7:0]  unused_n_tag;

    int total;
    int bad;

    always #5 clk = ~clk;

    dft_cplx_addsub u_dut (
        .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_op_i(s_op), .s_a_re_i(a_re), .s_a_im_i(a_im), .s_b_re_i(b_re), .s_b_im_i(b_im),
        .s_tag_i(s_tag), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_re_o(m_re),
        .m_im_o(m_im), .m_tag_o(m_tag), .m_ovf_o(m_ovf), .ovf_sticky_o(ovf_sticky),
        .clr_ovf_i(clr_ovf)
    );

    dft_cplx_addsub #(.DATA_SIGNED(1'b0)) u_uns (
        .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid), .s_ready_o(unused_u_ready),
        .s_op_i(s_op), .s_a_re_i(a_re), .s_a_im_i(a_im), .s_b_re_i(b_re), .s_b_im_i(b_im),
        .s_tag_i(s_tag), .m_valid_o(u_m_valid), .m_ready_i(m_ready), .m_re_o(u_re),
        .m_im_o(u_im), .m_tag_o(unused_u_tag), .m_ovf_o(u_m_ovf), .ovf_sticky_o(u_sticky),
        .clr_ovf_i(clr_ovf)
    );

    dft_cplx_addsub #(.DATA_SIGNED(1'b0), .SATURATE(1'b0)) u_uns_ns (
        .clk_i(clk), .rst_ni(rst_n), .s_valid_i(s_valid), .s_ready_o(unused_n_ready),
        .s_op_i(s_op), .s_a_re_i(a_re), .s_a_im_i(a_im), .s_b_re_i(b_re), .s_b_im_i(b_im),
        .s_tag_i(s_tag), .m_valid_o(n_m_valid), .m_ready_i(m_ready), .m_re_o(n_re),
        .m_im_o(n_im), .m_tag_o(unused_n_tag), .m_ovf_o(n_m_ovf), .ovf_sticky_o(n_sticky),
        .clr_ovf_i(clr_ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] ar, input logic [15:0] ai,
                         input logic [15:0] br, input logic [15:0] bi, input logic [7:0] tg);
        s_valid = 1'b1;
        s_op    = op;
        a_re    = ar;
        a_im    = ai;
        b_re    = br;
        b_im    = bi;
        s_tag   = tg;
    endtask

    task automatic idle();
        s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcvd;
        int cyc;
        logic held;
        logic [7:0] prev_tag;
        logic [15:0] prev_re;

        total = 0;
        bad = 0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        clr_ovf = 1'b0;
        s_op = 2'b00;
        a_re = '0;
        a_im = '0;
        b_re = '0;
        b_im = '0;
        s_tag = '0;

        // Reset state
        #12;
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_ovf", m_ovf, 0);
        check_eq("rst_sticky", ovf_sticky, 0);
        rst_n = 1'b1;
        check_eq("rst_s_ready", s_ready, 1);
        tick();
        check_eq("rst_m_re", m_re, 0);
        check_eq("rst_m_tag", m_tag, 0);

        // a - b, latency 2
        drive(2'b01, 16'd100, 16'hFFFB, 16'd30, 16'd7, 8'h11);
        tick();
        idle();
        check_eq("sub_early", m_valid, 0);
        tick();
        check_eq("sub_valid", m_valid, 1);
        check_eq("sub_re", m_re, 16'd70);
        check_eq("sub_im", m_im, 16'hFFF4);
        check_eq("sub_ovf", m_ovf, 0);
        check_eq("sub_tag", m_tag, 8'h11);
        tick();
        check_eq("sub_drained", m_valid, 0);

        // Signed positive saturation and sticky flag
        drive(2'b00, 16'h7FFF, 16'd0, 16'd1, 16'd0, 8'h22);
        tick();
        idle();
        tick();
        check_eq("sat_re", m_re, 16'h7FFF);
        check_eq("sat_ovf", m_ovf, 1);
        check_eq("sat_tag", m_tag, 8'h22);
        check_eq("sat_sticky_pre", ovf_sticky, 0);
        check_eq("sat_uns_re", u_re, 16'h8000);
        check_eq("sat_uns_ovf", u_m_ovf, 0);
        tick();
        check_eq("sat_sticky_set", ovf_sticky, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("sat_sticky_clr", ovf_sticky, 0);

        // Clear wins over a same-cycle overflowing transfer
        drive(2'b00, 16'h7FFF, 16'd0, 16'd1, 16'd0, 8'h23);
        tick();
        idle();
        tick();
        check_eq("prio_ovf", m_ovf, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_eq("prio_sticky", ovf_sticky, 0);

        // a - j*b then b - a, back to back
        drive(2'b11, 16'd10, 16'd20, 16'd3, 16'd4, 8'h31);
        tick();
        drive(2'b10, 16'd10, 16'd20, 16'd3, 16'd4, 8'h32);
        tick();
        idle();
        check_eq("subj_valid", m_valid, 1);
        check_eq("subj_re", m_re, 16'd14);
        check_eq("subj_im", m_im, 16'd17);
        check_eq("subj_tag", m_tag, 8'h31);
        tick();
        check_eq("rsub_valid", m_valid, 1);
        check_eq("rsub_re", m_re, 16'hFFF9);
        check_eq("rsub_im", m_im, 16'hFFF0);
        check_eq("rsub_tag", m_tag, 8'h32);
        tick();
        check_eq("rsub_drained", m_valid, 0);

        // Unsigned underflow
        drive(2'b01, 16'd5, 16'd0, 16'd9, 16'd0, 8'h41);
        tick();
        idle();
        tick();
        check_eq("uns_valid", u_m_valid, 1);
        check_eq("uns_re", u_re, 16'd0);
        check_eq("uns_im", u_im, 16'd0);
        check_eq("uns_ovf", u_m_ovf, 1);
        check_eq("ns_valid", n_m_valid, 1);
        check_eq("ns_re", n_re, 17'h1FFFC);
        check_eq("ns_ovf", n_m_ovf, 0);
        check_eq("sgn_neg_re", m_re, 16'hFFFC);
        check_eq("sgn_neg_ovf", m_ovf, 0);
        tick();

        // Unsigned overflow
        drive(2'b00, 16'hFFFF, 16'd0, 16'd1, 16'd0, 8'h42);
        tick();
        idle();
        tick();
        check_eq("uns_hi_re", u_re, 16'hFFFF);
        check_eq("uns_hi_ovf", u_m_ovf, 1);
        check_eq("ns_hi_re", n_re, 17'h10000);
        check_eq("sgn_wrap_re", m_re, 16'd0);
        check_eq("sgn_wrap_ovf", m_ovf, 0);
        tick();

        // Signed negative saturation on re
        drive(2'b01, 16'h8000, 16'd0, 16'd1, 16'd0, 8'h43);
        tick();
        idle();
        tick();
        check_eq("neg_sat_re", m_re, 16'h8000);
        check_eq("neg_sat_ovf", m_ovf, 1);
        check_eq("neg_uns_re", u_re, 16'h7FFF);
        check_eq("neg_uns_ovf", u_m_ovf, 0);
        tick();

        // Signed negative saturation on im through a - j*b
        drive(2'b11, 16'd0, 16'h8000, 16'd1, 16'd0, 8'h44);
        tick();
        idle();
        tick();
        check_eq("imsat_re", m_re, 16'd0);
        check_eq("imsat_im", m_im, 16'h8000);
        check_eq("imsat_ovf", m_ovf, 1);
        check_eq("imsat_ns_im", n_im, 17'h07FFF);
        tick();
        check_eq("uns_sticky", u_sticky, 1);
        check_eq("ns_sticky", n_sticky, 0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // Backpressure: fill two slices with m_ready low
        m_ready = 1'b0;
        drive(2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 8'd0);
        #1;
        check_eq("bp_rdy0", s_ready, 1);
        tick();
        drive(2'b00, 16'd100, 16'd0, 16'd1, 16'd0, 8'd1);
        #1;
        check_eq("bp_rdy1", s_ready, 1);
        tick();
        drive(2'b00, 16'd200, 16'd0, 16'd2, 16'd0, 8'd2);
        #1;
        check_eq("bp_full", s_ready, 0);
        m_ready = 1'b1;
        #1;
        check_eq("bp_comb_ready", s_ready, 1);

        sent = 2;
        rcvd = 0;
        cyc = 0;
        held = 1'b0;
        prev_tag = '0;
        prev_re = '0;
        while (rcvd < 10 && cyc < 300) begin
            if (held) begin
                check_eq("bp_hold_tag", m_tag, prev_tag);
                check_eq("bp_hold_re", m_re, prev_re);
            end
            if (m_valid && m_ready) begin
                check_eq("bp_tag", m_tag, rcvd);
                check_eq("bp_re", m_re, rcvd * 101);
                rcvd++;
            end
            if (s_valid && s_ready) begin
                sent++;
            end
            held = m_valid && !m_ready;
            prev_tag = m_tag;
            prev_re = m_re;
            tick();
            cyc++;
            m_ready = 1'($urandom_range(0, 1));
            if (sent < 10) begin
                drive(2'b00, 16'(sent * 100), 16'd0, 16'(sent), 16'd0, 8'(sent));
            end else begin
                idle();
            end
            #1;
        end
        check_eq("bp_count", rcvd, 10);
        idle();
        m_ready = 1'b1;
        tick();
        tick();
        tick();

        // Reset with two beats in flight
        m_ready = 1'b0;
        drive(2'b00, 16'd1, 16'd0, 16'd1, 16'd0, 8'hA0);
        tick();
        drive(2'b00, 16'd1, 16'd0, 16'd1, 16'd0, 8'hA1);
        tick();
        idle();
        check_eq("mid_rst_pre", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", m_valid, 0);
        check_eq("mid_rst_tag", m_tag, 0);
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        check_eq("mid_rst_ready", s_ready, 1);
        drive(2'b00, 16'd1, 16'd0, 16'd2, 16'd0, 8'h55);
        tick();
        idle();
        check_eq("post_rst_early", m_valid, 0);
        tick();
        check_eq("post_rst_valid", m_valid, 1);
        check_eq("post_rst_tag", m_tag, 8'h55);
        check_eq("post_rst_re", m_re, 16'd3);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
